// File: rtl/cash_port_arbiter_pkg.sv
// Shared types and width helpers for the cash port arbiter.
package cash_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESPOND
   } arb_state_t;

   function automatic int unsigned index_width(input int unsigned count);
      return (count < 2) ? 1 : $clog2(count);
   endfunction

   // Counter must be able to hold timeout_cycles itself.
   function automatic int unsigned count_width(input int unsigned cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/cash_port_arbiter_rr_pick.sv
// Round-robin winner selection: lowest request at or above pointer, else lowest overall.
module rr_pick import cash_arb_pkg::*; #(
   parameter int unsigned requester_count = 4,
   parameter int unsigned index_size      = index_width(requester_count)
) (
   input  logic [requester_count-1:0] req,
   input  logic [index_size-1:0]      pointer,
   output logic [index_size-1:0]      winner,
   output logic                       any
);

   logic [requester_count-1:0] masked;
   logic [requester_count-1:0] pool;
   logic [requester_count-1:0] one_hot;
   logic                       found;

   always_comb begin
      masked  = '0;
      one_hot = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < requester_count; i++) begin
         masked[i] = req[i] && (i >= pointer);
      end
      pool = (|masked) ? masked : req;
      for (int unsigned i = 0; i < requester_count; i++) begin
         if (pool[i] && !found) begin
            one_hot[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign any = |req;

   encoder #(
      .width      (requester_count),
      .index_size (index_size)
   ) u_encoder (
      .one_hot (one_hot),
      .index   (winner)
   );

endmodule

// File: rtl/encoder.sv
// One-hot to binary index encoder.
module encoder #(
   parameter int unsigned width      = 4,
   parameter int unsigned index_size = 2
) (
   input  logic [width-1:0]      one_hot,
   output logic [index_size-1:0] index
);

   always_comb begin
      index = '0;
      for (int unsigned i = 0; i < width; i++) begin
         if (one_hot[i]) begin
            index = index | i[index_size-1:0];
         end
      end
   end

endmodule

// File: rtl/cash_port_arbiter.sv
// Round-robin sequencer sharing one single-ported resource between several client FSMs.
module cash_port_arbiter import cash_arb_pkg::*; #(
   parameter int unsigned requester_count = 4,
   parameter int unsigned address_size    = 4,
   parameter int unsigned data_size       = 4,
   parameter int unsigned timeout_cycles  = 15
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [requester_count-1:0]              req,
   input  logic [requester_count-1:0]              req_action,
   input  logic [requester_count*address_size-1:0] req_address,
   input  logic [requester_count*data_size-1:0]    req_data,
   output logic [requester_count-1:0]              grant,
   output logic [requester_count-1:0]              rsp_valid,
   output logic [data_size-1:0]                    rsp_data,
   output logic                                    rsp_error,
   output logic                                    res_start,
   output logic                                    res_action,
   output logic [address_size-1:0]                 res_address,
   output logic [data_size-1:0]                    res_data,
   input  logic                                    res_done,
   input  logic [data_size-1:0]                    res_result,
   output logic                                    busy
);

   localparam int unsigned iw = index_width(requester_count);
   localparam int unsigned cw = count_width(timeout_cycles);
   localparam logic [cw-1:0] timeout_value = cw'(timeout_cycles);
   localparam logic [iw-1:0] last_index    = iw'(requester_count - 1);

   arb_state_t                 state, state_next;
   logic [iw-1:0]              pointer, pick, winner;
   logic [cw-1:0]              count;
   logic                       any_req;
   logic [requester_count-1:0] grant_next, valid_next;
   logic                       start_next;

   rr_pick #(
      .requester_count (requester_count)
   ) u_pick (
      .req     (req),
      .pointer (pointer),
      .winner  (pick),
      .any     (any_req)
   );

   always_comb begin
      state_next = state;
      grant_next = '0;
      valid_next = '0;
      start_next = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next       = ISSUE;
               grant_next[pick] = 1'b1;
               start_next       = 1'b1;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (res_done || count == timeout_value) begin
               state_next         = RESPOND;
               valid_next[winner] = 1'b1;
            end
         end
         RESPOND: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pulses and busy are registered from the next state so no input reaches them combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         rsp_valid <= '0;
         res_start <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         grant     <= grant_next;
         rsp_valid <= valid_next;
         res_start <= start_next;
         busy      <= (state_next != IDLE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pointer     <= '0;
         winner      <= '0;
         count       <= '0;
         rsp_data    <= '0;
         rsp_error   <= 1'b0;
         res_action  <= 1'b0;
         res_address <= '0;
         res_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  winner      <= pick;
                  res_action  <= req_action[pick];
                  res_address <= req_address[pick*address_size +: address_size];
                  res_data    <= req_data[pick*data_size +: data_size];
               end
            end
            ISSUE: count <= '0;
            WAIT: begin
               if (res_done) begin
                  rsp_data  <= res_result;
                  rsp_error <= 1'b0;
               end else if (count == timeout_value) begin
                  rsp_data  <= '0;
                  rsp_error <= 1'b1;
               end else begin
                  count <= count + cw'(1);
               end
            end
            RESPOND: pointer <= (winner == last_index) ? '0 : winner + iw'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cash_port_arbiter.sv
// Directed table-driven bench for cash_port_arbiter with hand-written corner sequences.
module tb_cash_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req, req_action;
   logic [15:0] req_address, req_data;
   logic [3:0]  grant, rsp_valid, rsp_data;
   logic        rsp_error, res_start, res_action, busy, res_done;
   logic [3:0]  res_address, res_data, res_result;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] wait_req;
      int         done_at;   // WAIT-cycle index of res_done; -1 = during ISSUE; -100 = never
      logic [3:0] result;
      logic [3:0] exp_grant;
      logic [3:0] exp_addr;
      logic       exp_act;
      logic [3:0] exp_wdata;
      logic [3:0] exp_rdata;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   vec_t vecs[9];

   cash_port_arbiter #(
      .requester_count (4),
      .address_size    (4),
      .data_size       (4),
      .timeout_cycles  (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_action  (req_action),
      .req_address (req_address),
      .req_data    (req_data),
      .grant       (grant),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_error   (rsp_error),
      .res_start   (res_start),
      .res_action  (res_action),
      .res_address (res_address),
      .res_data    (res_data),
      .res_done    (res_done),
      .res_result  (res_result),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] all_outputs();
      return {8'h00, grant, rsp_valid, rsp_data, rsp_error, res_start, res_action,
              res_address, res_data, busy};
   endfunction

   task automatic run_txn(input vec_t v);
      int   n;
      logic got, side;
      req = v.req;
      @(posedge clk); #1;
      check("grant", grant, v.exp_grant);
      check("res_start", res_start, 1);
      check("busy_issue", busy, 1);
      check("res_address", res_address, v.exp_addr);
      check("res_action", res_action, v.exp_act);
      check("res_data", res_data, v.exp_wdata);
      req  = v.wait_req;
      n    = 0;
      got  = 1'b0;
      side = 1'b0;
      while (!got && n < 30) begin
         res_done   = (n == 1 + v.done_at);
         res_result = v.result;
         @(posedge clk); #1;
         n++;
         if (rsp_valid != 4'b0) got = 1'b1;
         else if (grant != 4'b0 || res_start) side = 1'b1;
      end
      res_done = 1'b0;
      req      = 4'b0;
      check("rsp_seen", got, 1);
      check("rsp_latency", n, v.exp_lat);
      check("rsp_valid", rsp_valid, v.exp_grant);
      check("rsp_data", rsp_data, v.exp_rdata);
      check("rsp_error", rsp_error, v.exp_err);
      check("no_pulse_in_wait", side, 0);
      check("res_address_hold", res_address, v.exp_addr);
      @(posedge clk); #1;
      check("rsp_valid_one_cycle", rsp_valid, 0);
      check("busy_idle", busy, 0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      check("reset_outputs", all_outputs(), 0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int   cyc, ngr, pend;
      int   gcyc[5];
      logic [3:0] gval[5];
      logic quiet;

      // client 3..0: address 7,3,5,9; data C,6,A,2; action 1,0,1,0
      req_address = 16'h7359;
      req_data    = 16'hC6A2;
      req_action  = 4'b1010;
      req         = 4'b0;
      res_done    = 1'b0;
      res_result  = 4'h0;
      reset       = 1'b1;

      //            req      wreq     done  res    grant    addr  act   wd     rd    err  lat
      vecs[0] = '{4'b0010, 4'b0000,    0, 4'hA, 4'b0010, 4'h5, 1'b1, 4'hA, 4'hA, 1'b0,  2};
      vecs[1] = '{4'b0100, 4'b0000,    1, 4'h3, 4'b0100, 4'h3, 1'b0, 4'h6, 4'h3, 1'b0,  3};
      vecs[2] = '{4'b0101, 4'b0000,    0, 4'h5, 4'b0001, 4'h9, 1'b0, 4'h2, 4'h5, 1'b0,  2};
      vecs[3] = '{4'b0101, 4'b0000, -100, 4'hB, 4'b0100, 4'h3, 1'b0, 4'h6, 4'h0, 1'b1, 17};
      vecs[4] = '{4'b1000, 4'b0000,   -1, 4'hF, 4'b1000, 4'h7, 1'b1, 4'hC, 4'h0, 1'b1, 17};
      vecs[5] = '{4'b0001, 4'b0000,   15, 4'h9, 4'b0001, 4'h9, 1'b0, 4'h2, 4'h9, 1'b0, 17};
      vecs[6] = '{4'b0011, 4'b1111,    2, 4'h4, 4'b0010, 4'h5, 1'b1, 4'hA, 4'h4, 1'b0,  4};
      vecs[7] = '{4'b1001, 4'b0000,    0, 4'hE, 4'b1000, 4'h7, 1'b1, 4'hC, 4'hE, 1'b0,  2};
      vecs[8] = '{4'b1001, 4'b0000,    0, 4'h1, 4'b0001, 4'h9, 1'b0, 4'h2, 4'h1, 1'b0,  2};

      #2;
      check("reset_outputs", all_outputs(), 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", all_outputs(), 0);

      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // Reset in the middle of WAIT abandons the op and clears the pointer
      req = 4'b0100;
      @(posedge clk); #1;
      check("mid_grant", grant, 4'b0100);
      req = 4'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2;
      pulse_reset();
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (rsp_valid != 4'b0 || busy) quiet = 1'b0;
      end
      check("no_rsp_after_reset", quiet, 1);
      run_txn('{4'b1001, 4'b0000, 0, 4'h7, 4'b0001, 4'h9, 1'b0, 4'h2, 4'h7, 1'b0, 2});

      // Fairness with all clients requesting continuously
      pulse_reset();
      req  = 4'b1111;
      ngr  = 0;
      pend = 0;
      cyc  = 0;
      while (ngr < 5 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         res_done   = (pend != 0);
         res_result = 4'h3;
         pend       = res_start ? 1 : 0;
         if (grant != 4'b0) begin
            gval[ngr] = grant;
            gcyc[ngr] = cyc;
            ngr++;
         end
      end
      check("fair_grant_count", ngr, 5);
      check("fair_first_cycle", gcyc[0], 1);
      for (int k = 0; k < 5; k++) begin
         if (k < ngr) begin
            check("fair_order", gval[k], 4'b0001 << (k % 4));
            if (k > 0) check("fair_spacing", gcyc[k] - gcyc[k-1], 4);
         end
      end
      req = 4'b0;
      for (int i = 0; i < 10 && busy; i++) begin
         @(posedge clk); #1;
         res_done = (pend != 0);
         pend     = 0;
      end
      res_done = 1'b0;
      check("fair_drain_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cash_port_arbiter.md
# cash_port_arbiter

Round-robin arbiter and sequencer that shares one single-ported cache/resource port (e.g. the fast unordered cash) between `requester_count` clients. It latches one client's operation, drives a start pulse to the shared port, and waits for completion or timeout. It then returns the result to that client only. Sits between client FSMs (UART RX path, counters, etc.) and the shared storage block.

## Interface
Parameters:
- `requester_count`, 4: number of clients, ≥2.
- `address_size`, 4: address width.
- `data_size`, 4: data width.
- `timeout_cycles`, 15: maximum WAIT cycles before forced error completion, ≥1.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  requester_count  per-client request level.
- `req_action`  in  requester_count  per-client op (0 read, 1 write).
- `req_address`  in  requester_count*address_size  packed, client i at [i*address_size +: address_size].
- `req_data`  in  requester_count*data_size  packed write data, same packing.
- `grant`  out  requester_count  one-hot, one-cycle pulse: request accepted.
- `rsp_valid`  out  requester_count  one-hot, one-cycle pulse: result ready.
- `rsp_data`  out  data_size  result, valid with `rsp_valid`.
- `rsp_error`  out  1  timeout flag, valid with `rsp_valid`.
- `res_start`  out  1  one-cycle start pulse to shared port.
- `res_action`, `res_address`, `res_data`  out  1/address_size/data_size  latched op, stable from ISSUE through WAIT.
- `res_done`  in  1  completion pulse from shared port.
- `res_result`  in  data_size  result, sampled with `res_done`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: if any `req` bit is set, pick the winner. The winner is the lowest index ≥ `pointer` with `req` set, else the lowest index overall (wrap). Latch winner index, action, address and data. Go to ISSUE. With no request, stay in IDLE.
- ISSUE: `grant[winner]`=1 and `res_start`=1 for this cycle only. Go to WAIT. Clear the timeout counter.
- WAIT: on `res_done`=1, latch `res_result` into `rsp_data`, set `rsp_error`=0, and go to RESPOND. Otherwise increment the counter. When the counter reaches `timeout_cycles` without `res_done`, set `rsp_data`=0 and `rsp_error`=1, then go to RESPOND.
- RESPOND: `rsp_valid[winner]`=1 for one cycle. Set `pointer` to (winner+1) mod requester_count. Go to IDLE.
- `req` is sampled only in IDLE. A client must drop `req` after `grant`, or it is re-arbitrated as a new request. `req` changes outside IDLE are ignored.
- `res_done` in ISSUE, RESPOND or IDLE is ignored (no state change, no error).
- `res_done` arriving in the same cycle the counter hits `timeout_cycles`: done wins, `rsp_error`=0.
- Reset, including mid-operation: state IDLE, `pointer`=0, all outputs 0. The in-flight op is abandoned and no `rsp_valid` is issued.

## Timing
- `req` seen in IDLE at cycle 0: `grant`/`res_start` at cycle 1, earliest `res_done` at cycle 2, `rsp_valid` at cycle 3, next grant earliest at cycle 5.
- Timeout path: `rsp_valid` is `timeout_cycles`+2 cycles after ISSUE.
- `grant`, `rsp_valid`, `res_start` and `busy` are registered, with no combinational path from inputs.
- `res_*` outputs hold their values until the next IDLE capture.

## Structure
- Package `cash_arb_pkg`: state enum (IDLE, ISSUE, WAIT, RESPOND), width function `index_width = $clog2(requester_count)`, timeout counter width.
- One sub-module, `rr_pick`: a combinational rotate-mask plus priority pick. It reuses the codebase `encoder` to convert the masked one-hot request into a winner index, and outputs an `any` flag.

## Test plan
- Single client: requester_count=4, `req`=0010, action 1, address 0x5, data 0xA, `res_done` in the cycle after start with `res_result`=0xA. Required: `grant`=0010 at cycle 1, `res_address`=0x5, `rsp_valid`=0010 at cycle 3, `rsp_data`=0xA, `rsp_error`=0.
- Fairness: all `req`=1111 held continuously, `res_done` in the cycle after start. Required: grant order 0,1,2,3,0, one grant per 4-cycle transaction.
- Wrap: `pointer`=3 after serving client 2, then `req`=0101. Required: grant goes to client 0, then client 2.
- Timeout: `res_done` never asserted. Required: `rsp_valid` at ISSUE+17 cycles, `rsp_error`=1, `rsp_data`=0, FSM back in IDLE with `pointer` advanced.
- Stray/simultaneous events: `res_done` pulsed in ISSUE is ignored, and `res_done` in the final timeout cycle gives `rsp_error`=0. A `req` change during WAIT is ignored.
- Reset mid-WAIT: assert `reset` asynchronously. Required: all outputs 0 immediately, no `rsp_valid`, and the next grant goes to the lowest requesting index from `pointer`=0.
